// File: rtl/rf_frame_rx.sv
// rf_frame_rx: frame receiver behind the Manchester decoder.
// Hunts for a 16-bit sync word, then reads a length byte and the payload
// bytes (MSB first) and reports them with single-cycle strobes. An
// end-of-frame status follows.
// Optional feature macro: RF_FRAME_CRC_EN. When it is defined, a trailing
// CRC-8 byte (poly 0x07, init 0x00) covering the length and payload is
// checked.
// rx_eof is never in the same cycle as rx_valid. Without the CRC, the FSM
// therefore spends one settle cycle in PAYLOAD after the last byte before
// it enters END.
module rf_frame_rx #(
    parameter logic [15:0] SYNC_WORD = 16'h2DD4,
    parameter int unsigned MAX_LEN   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       bit_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_ok,
    output logic       busy
);

    localparam logic [7:0] MAX_B = MAX_LEN[7:0];

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
`ifdef RF_FRAME_CRC_EN
        S_CRC,
`endif
        S_END
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] win_q, win_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        ok_q, ok_d;
    logic [7:0]  data_q, data_d;
    logic        vld_q, vld_d;
    logic        sof_q, sof_d;
`ifdef RF_FRAME_CRC_EN
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  crc_nxt;
`endif

    logic [7:0]  byte_w;
    logic [15:0] win_sh;
    logic        byte_done;

    assign byte_w    = {sh_q[6:0], bit_in};
    assign win_sh    = {win_q[14:0], bit_in};
    assign byte_done = bit_valid && (bcnt_q == 3'd7);
`ifdef RF_FRAME_CRC_EN
    assign crc_nxt = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_in) ? 8'h07 : 8'h00);
`endif

    // State and datapath registers; reset drops the frame with no eof
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HUNT;
            win_q   <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            ok_q    <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
`ifdef RF_FRAME_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            ok_q    <= ok_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
`ifdef RF_FRAME_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    // Next-state: sync hunt, byte assembly, length and payload tracking
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        ok_d    = ok_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
`ifdef RF_FRAME_CRC_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            S_HUNT: begin
                if (bit_valid) begin
                    if (bit_err) begin
                        win_d = '0;
                    end else begin
                        win_d = win_sh;
                        if (win_sh == SYNC_WORD) begin
                            state_d = S_LEN;
                            bcnt_d  = '0;
`ifdef RF_FRAME_CRC_EN
                            crc_d   = '0;
`endif
                        end
                    end
                end
            end
            S_LEN: begin
                if (bit_valid) begin
                    if (bit_err) begin
                        state_d = S_END;
                        ok_d    = 1'b0;
                    end else begin
                        sh_d   = byte_w;
                        bcnt_d = bcnt_q + 3'd1;
`ifdef RF_FRAME_CRC_EN
                        crc_d  = crc_nxt;
`endif
                        if (byte_done) begin
                            cnt_d = byte_w;
                            if (byte_w == 8'd0 || byte_w > MAX_B) begin
                                state_d = S_END;
                                ok_d    = 1'b0;
                            end else begin
                                state_d = S_PAYLOAD;
                                first_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_PAYLOAD: begin
`ifndef RF_FRAME_CRC_EN
                // All bytes delivered: settle one cycle, then report success
                if (cnt_q == 8'd0) begin
                    state_d = S_END;
                    ok_d    = 1'b1;
                end else
`endif
                if (bit_valid) begin
                    if (bit_err) begin
                        state_d = S_END;
                        ok_d    = 1'b0;
                    end else begin
                        sh_d   = byte_w;
                        bcnt_d = bcnt_q + 3'd1;
`ifdef RF_FRAME_CRC_EN
                        crc_d  = crc_nxt;
`endif
                        if (byte_done) begin
                            vld_d   = 1'b1;
                            data_d  = byte_w;
                            sof_d   = first_q;
                            first_d = 1'b0;
                            cnt_d   = cnt_q - 8'd1;
`ifdef RF_FRAME_CRC_EN
                            if (cnt_q == 8'd1) state_d = S_CRC;
`endif
                        end
                    end
                end
            end
`ifdef RF_FRAME_CRC_EN
            S_CRC: begin
                if (bit_valid) begin
                    if (bit_err) begin
                        state_d = S_END;
                        ok_d    = 1'b0;
                    end else begin
                        sh_d   = byte_w;
                        bcnt_d = bcnt_q + 3'd1;
                        if (byte_done) begin
                            state_d = S_END;
                            ok_d    = (byte_w == crc_q);
                        end
                    end
                end
            end
`endif
            S_END: begin
                state_d = S_HUNT;
                win_d   = '0;
                bcnt_d  = '0;
                ok_d    = 1'b0;
            end
            default: state_d = S_HUNT;
        endcase
    end

    assign rx_data  = data_q;
    assign rx_valid = vld_q;
    assign rx_sof   = sof_q;
    assign rx_eof   = (state_q == S_END);
    assign rx_ok    = (state_q == S_END) && ok_q;
    assign busy     = (state_q != S_HUNT);

endmodule
